// File: rtl/conv_stream_pkg.sv
// rtl/conv_stream_pkg.sv - shared types and helpers for the conv pixel-stream transmitter
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } tx_state_t;

  function automatic int pixels(input int image_width);
    return image_width * image_width;
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - one-frame pixel store, synchronous write, combinational read
module frame_buffer #(
  parameter int BitSize = 4,
  parameter int Depth   = 64,
  parameter int AddrW   = 6
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AddrW-1:0]   waddr_i,
  input  logic [BitSize-1:0] wdata_i,
  input  logic [AddrW-1:0]   raddr_i,
  output logic [BitSize-1:0] rdata_o
);

  logic [BitSize-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read is combinational so the next pixel can be registered without a bubble.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/image_stream_tx.sv
// rtl/image_stream_tx.sv - buffers one frame and streams it with backpressure, then flushes
import conv_stream_pkg::*;

module image_stream_tx #(
  parameter int BitSize     = 4,
  parameter int ImageWidth  = 8,
  parameter int FlushCycles = 448
) (
  input  logic               clk,
  input  logic               res,
  input  logic               ld_valid,
  input  logic [BitSize-1:0] ld_data,
  output logic               ld_ready,
  input  logic               start,
  output logic               tx_valid,
  output logic [BitSize-1:0] tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int Pixels = pixels(ImageWidth);
  localparam int CntW   = $clog2(Pixels + 1);
  localparam int FlW    = (FlushCycles > 0) ? $clog2(FlushCycles + 1) : 1;
  localparam int AddrW  = (Pixels > 1) ? $clog2(Pixels) : 1;
  localparam logic [CntW-1:0] LastPix = CntW'(Pixels - 1);
  localparam logic [FlW-1:0]  LastFl  = FlW'((FlushCycles > 0) ? FlushCycles - 1 : 0);

  tx_state_t          state_q, state_d;
  logic [CntW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [FlW-1:0]     fl_cnt_q, fl_cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic [BitSize-1:0] tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               buf_we;
  logic [BitSize-1:0] buf_rdata;

  assign buf_we = (state_q == IDLE) && ld_valid && !res;

  frame_buffer #(
    .BitSize(BitSize),
    .Depth  (Pixels),
    .AddrW  (AddrW)
  ) u_frame_buffer (
    .clk    (clk),
    .we_i   (buf_we),
    .waddr_i(wr_cnt_q[AddrW-1:0]),
    .wdata_i(ld_data),
    .raddr_i(rd_cnt_d[AddrW-1:0]),
    .rdata_o(buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    fl_cnt_d = fl_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          if (wr_cnt_q == LastPix) begin
            state_d  = FULL;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_d  = STREAM;
          rd_cnt_d = '0;
        end
      end
      STREAM: begin
        if (tx_ready) begin
          if (rd_cnt_q == LastPix) begin
            rd_cnt_d = '0;
            fl_cnt_d = '0;
            // With no flush the frame completes on its last pixel beat.
            if (FlushCycles == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (tx_ready) begin
          if (fl_cnt_q == LastFl) begin
            state_d  = IDLE;
            fl_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            fl_cnt_d = fl_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so pixel 0 appears right after start.
  always_comb begin
    tx_valid_d = (state_d == STREAM);
    tx_data_d  = (state_d == STREAM) ? buf_rdata : '0;
    busy_d     = (state_d == STREAM) || (state_d == FLUSH);
  end

  assign ld_ready = (state_q == IDLE);
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_stream_tx.sv
// tb/tb_image_stream_tx.sv - scoreboard bench for image_stream_tx, default and no-flush builds
module tb_image_stream_tx;

  localparam int Pixels = 64;

  logic       clk;
  logic       res;
  logic       ld_valid;
  logic [3:0] ld_data;
  logic       start;
  logic       tx_ready;
  logic       ld_ready, tx_valid, busy, done;
  logic [3:0] tx_data;
  logic       ld_ready0, tx_valid0, busy0, done0;
  logic [3:0] tx_data0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  image_stream_tx #(.BitSize(4), .ImageWidth(8), .FlushCycles(448)) dut (
    .clk(clk), .res(res), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  image_stream_tx #(.BitSize(4), .ImageWidth(8), .FlushCycles(0)) dut0 (
    .clk(clk), .res(res), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0),
    .start(start), .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready),
    .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic load_frame(input int mode, output int accepted);
    accepted = 0;
    for (int i = 0; i < Pixels + 4; i++) begin
      ld_valid = 1'b1;
      if (i < Pixels) begin
        ld_data = (mode == 0) ? 4'(i % 16) : 4'((i * 3 + 5) % 16);
        exp_q.push_back(ld_data);
      end else begin
        ld_data = 4'hA;
      end
      if (ld_ready === 1'b1) accepted++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  task automatic test_reset();
    res = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 4'h0 || ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: tx_valid=%b tx_data=%h ld_ready=%b busy=%b done=%b, required 0 0 1 0 0",
               tx_valid, tx_data, ld_ready, busy, done);
    end
    n_checks++;
    if (tx_valid0 !== 1'b0 || ld_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values_noflush: tx_valid=%b ld_ready=%b busy=%b done=%b, required 0 1 0 0",
               tx_valid0, ld_ready0, busy0, done0);
    end
    res = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: ld_ready=%b busy=%b, required 1 0", ld_ready, busy);
    end
  endtask

  task automatic test_load();
    int acc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_idle: busy=%b tx_valid=%b ld_ready=%b, required 0 0 1", busy, tx_valid, ld_ready);
    end
    load_frame(0, acc);
    n_checks++;
    if (acc != Pixels) begin
      n_fail++;
      $display("FAIL load_accepted: got %0d beats, required %0d", acc, Pixels);
    end
    n_checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || ld_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: ld_ready=%b busy=%b tx_valid=%b ld_ready0=%b, required 0 0 0 0",
               ld_ready, busy, tx_valid, ld_ready0);
    end
  endtask

  task automatic test_stream();
    int hs = 0;
    int done_at = -1;
    int flush_cyc = 0;
    logic [3:0] exp;
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (c == 1) begin
        n_checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_latency: tx_valid=%b busy=%b, required 1 1", tx_valid, busy);
        end
      end
      if (c == 64) begin
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
          n_fail++;
          $display("FAIL noflush_before_done: done=%b busy=%b, required 0 1", done0, busy0);
        end
      end
      if (c == 65) begin
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || tx_valid0 !== 1'b0) begin
          n_fail++;
          $display("FAIL noflush_done: done=%b busy=%b tx_valid=%b, required 1 0 0", done0, busy0, tx_valid0);
        end
      end
      if (tx_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: pixel %0d data=%h, required no more pixels", hs, tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin
            n_fail++;
            $display("FAIL stream_data: pixel %0d got %h, required %h", hs, tx_data, exp);
          end
        end
        n_checks++;
        if (c != hs + 1) begin
          n_fail++;
          $display("FAIL stream_gap: pixel %0d in cycle %0d, required cycle %0d", hs, c, hs + 1);
        end
        hs++;
      end else if (done === 1'b1) begin
        done_at = c;
        break;
      end else begin
        flush_cyc++;
        n_checks++;
        if (tx_data !== 4'h0) begin
          n_fail++;
          $display("FAIL flush_data: cycle %0d got %h, required 0", c, tx_data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (hs != Pixels || done_at != 513 || flush_cyc != 448) begin
      n_fail++;
      $display("FAIL stream_totals: pixels=%0d done_cycle=%0d flush=%0d, required 64 513 448", hs, done_at, flush_cyc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_done: got %b, required 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b busy=%b ld_ready=%b, required 0 0 1", done, busy, ld_ready);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int hs = 0;
    int done_at = -1;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [3:0] prev_data = '0;
    logic [3:0] exp;
    load_frame(0, acc);
    n_checks++;
    if (acc != Pixels) begin
      n_fail++;
      $display("FAIL reload_accepted: got %0d beats, required %0d", acc, Pixels);
    end
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      tx_ready = (c % 2 == 1);
      start = (c == 10 || c == 31);
      if (prev_valid && !prev_ready) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: cycle %0d valid=%b data=%h, required 1 %h", c, tx_valid, tx_data, prev_data);
        end
      end
      if (c == 128) begin
        n_checks++;
        if (done0 !== 1'b1) begin
          n_fail++;
          $display("FAIL noflush_done_bp: done=%b, required 1", done0);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: pixel %0d data=%h, required no more pixels", hs, tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin
            n_fail++;
            $display("FAIL bp_data: pixel %0d got %h, required %h", hs, tx_data, exp);
          end
        end
        hs++;
      end else if (done === 1'b1) begin
        done_at = c;
        break;
      end else if (tx_valid !== 1'b1) begin
        n_checks++;
        if (tx_data !== 4'h0) begin
          n_fail++;
          $display("FAIL bp_flush_data: cycle %0d got %h, required 0", c, tx_data);
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      @(negedge clk);
    end
    start = 1'b0;
    tx_ready = 1'b1;
    n_checks++;
    if (hs != Pixels || done_at != 1024) begin
      n_fail++;
      $display("FAIL bp_totals: pixels=%0d done_cycle=%0d, required 64 1024", hs, done_at);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_restart: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int acc;
    int hs = 0;
    int done_at = -1;
    logic [3:0] exp;
    load_frame(0, acc);
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (tx_valid === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (tx_data !== exp) begin
          n_fail++;
          $display("FAIL pre_reset_data: pixel %0d got %h, required %h", hs, tx_data, exp);
        end
        if (hs == 20) begin
          res = 1'b1;
          break;
        end
        hs++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (hs != 20 || res !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_pixel20: reached %0d, required 20", hs);
    end
    @(negedge clk);
    res = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1 || done !== 1'b0 || tx_data !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_reset: tx_valid=%b busy=%b ld_ready=%b done=%b tx_data=%h, required 0 0 1 0 0",
               tx_valid, busy, ld_ready, done, tx_data);
    end
    exp_q.delete();
    load_frame(1, acc);
    n_checks++;
    if (acc != Pixels) begin
      n_fail++;
      $display("FAIL post_reset_load: got %0d beats, required %0d", acc, Pixels);
    end
    hs = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (tx_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL restream_extra: pixel %0d data=%h, required no more pixels", hs, tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin
            n_fail++;
            $display("FAIL restream_data: pixel %0d got %h, required %h", hs, tx_data, exp);
          end
        end
        hs++;
      end else if (done === 1'b1) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (hs != Pixels || done_at != 513) begin
      n_fail++;
      $display("FAIL restream_totals: pixels=%0d done_cycle=%0d, required 64 513", hs, done_at);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
